// File: rtl/aes_output_collector.sv
// Output-side collector for aes_pipelined: FWFT FIFO with sticky overflow, run block counter and done flag.
// Define AES_COLLECT_PERF_EN to build the elapsed_cycles counter; otherwise elapsed_cycles is tied to 0.
module aes_output_collector #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 128,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic [DATA_W-1:0]        in_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [DATA_W-1:0]        m_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  input  logic                     start,
  input  logic [CNT_W-1:0]         expected_blocks,
  output logic [CNT_W-1:0]         blk_count,
  output logic                     done,
  output logic [31:0]              elapsed_cycles
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr, rd_ptr_inc;
  logic [AW:0]       count;
  logic [DATA_W-1:0] head;
  logic              full, push, pop, drop;

  logic [1:0]        state;
  logic [CNT_W-1:0]  exp_reg, cnt_inc;
  logic              met;

  assign full       = (count == FULL_LVL);
  assign pop        = (count != '0) && m_ready;
  assign push       = in_valid && (!full || pop);
  assign drop       = in_valid && full && !pop;
  assign rd_ptr_inc = rd_ptr + 1'b1;

  assign m_valid = (count != '0);
  assign m_data  = head;
  assign level   = count;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  // head is a register so m_data never depends combinationally on in_data
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      head   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr_inc;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      if (push && (count == '0 || (count == (AW+1)'(1) && pop)))
        head <= in_data;
      else if (pop && count > (AW+1)'(1))
        head <= mem[rd_ptr_inc];
    end
  end

  assign cnt_inc = (blk_count == '1) ? blk_count : blk_count + 1'b1;
  // already satisfied on entry to RUN (expected_blocks of zero)
  assign met     = (blk_count >= exp_reg);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      exp_reg   <= '0;
      blk_count <= '0;
      done      <= 1'b0;
      overflow  <= 1'b0;
    end else if (start) begin
      exp_reg   <= expected_blocks;
      blk_count <= push ? CNT_W'(1) : '0;
      overflow  <= drop;
      if (push && expected_blocks == CNT_W'(1)) begin
        state <= DONE;
        done  <= 1'b1;
      end else begin
        state <= RUN;
        done  <= 1'b0;
      end
    end else begin
      if (drop) overflow <= 1'b1;
      if (state == RUN) begin
        if (met) begin
          state <= DONE;
          done  <= 1'b1;
        end else if (push) begin
          blk_count <= cnt_inc;
          if (cnt_inc == exp_reg) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
      end
    end
  end

`ifdef AES_COLLECT_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst_n || start)
      elapsed_cycles <= '0;
    else if (state == RUN && !met && elapsed_cycles != '1)
      elapsed_cycles <= elapsed_cycles + 1'b1;
  end
`else
  assign elapsed_cycles = '0;
`endif

endmodule

// File: tb/tb_aes_output_collector.sv
// Randomized bench for aes_output_collector against a queue-based reference model.
module tb_aes_output_collector;
  localparam int DEPTH = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic [127:0] in_data = '0;
  logic         m_valid;
  logic         m_ready = 1'b0;
  logic [127:0] m_data;
  logic [4:0]   level;
  logic         overflow;
  logic         start = 1'b0;
  logic [15:0]  expected_blocks = '0;
  logic [15:0]  blk_count;
  logic         done;
  logic [31:0]  elapsed_cycles;

  int errors = 0;
  int checks = 0;

  // reference model state
  logic [127:0] q[$];
  bit           ref_ovf, ref_run, ref_done;
  int           ref_cnt, ref_exp;
  longint       ref_el;

  aes_output_collector #(.DEPTH(DEPTH), .DATA_W(128), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .level(level),
    .overflow(overflow), .start(start), .expected_blocks(expected_blocks),
    .blk_count(blk_count), .done(done), .elapsed_cycles(elapsed_cycles)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic model_edge();
    bit pop, push, drop;
    if (!rst_n) begin
      q.delete();
      ref_ovf = 0; ref_run = 0; ref_done = 0; ref_cnt = 0; ref_exp = 0; ref_el = 0;
      return;
    end
    pop  = (q.size() > 0) && m_ready;
    push = in_valid && (q.size() < DEPTH || pop);
    drop = in_valid && !push;
    if (pop)  void'(q.pop_front());
    if (push) q.push_back(in_data);
    if (start) begin
      ref_exp = expected_blocks;
      ref_cnt = push ? 1 : 0;
      ref_el  = 0;
      ref_ovf = drop;
      ref_done = push && expected_blocks == 1;
      ref_run  = !ref_done;
    end else begin
      if (drop) ref_ovf = 1;
      if (ref_run) begin
        if (ref_cnt >= ref_exp) begin
          ref_run = 0; ref_done = 1;
        end else begin
          if (ref_el < 64'hFFFF_FFFF) ref_el++;
          if (push) begin
            if (ref_cnt < 65535) ref_cnt++;
            if (ref_cnt == ref_exp) begin
              ref_run = 0; ref_done = 1;
            end
          end
        end
      end
    end
  endtask

  task automatic compare_all();
    longint exp_el;
`ifdef AES_COLLECT_PERF_EN
    exp_el = ref_el;
`else
    exp_el = 0;
`endif
    check("m_valid", m_valid, q.size() > 0);
    if (q.size() > 0) check("m_data", m_data, q[0]);
    check("level", level, q.size());
    check("overflow", overflow, ref_ovf);
    check("blk_count", blk_count, ref_cnt);
    check("done", done, ref_done);
    check("elapsed", elapsed_cycles, exp_el);
  endtask

  // one clock: apply inputs, advance the model at the edge, sample 1ns later
  task automatic step(input logic iv, input logic [127:0] d, input logic rdy,
                      input logic st, input logic [15:0] eb);
    in_valid = iv; in_data = d; m_ready = rdy; start = st; expected_blocks = eb;
    @(posedge clk);
    model_edge();
    #1;
    $display("cyc rst_n=%0b iv=%0b rdy=%0b st=%0b lvl=%0d ovf=%0b cnt=%0d done=%0b el=%0d",
             rst_n, iv, rdy, st, level, overflow, blk_count, done, elapsed_cycles);
    compare_all();
  endtask

  initial begin
    logic [127:0] kat;
    kat = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    rst_n = 0;
    step(0, '0, 0, 0, 0);
    step(0, '0, 0, 0, 0);
    check("reset_m_data", m_data, 128'h0);
    rst_n = 1;

    // single push, then one-cycle pop
    step(1, kat, 0, 0, 0);
    check("kat_head", m_data, kat);
    step(0, '0, 0, 0, 0);
    step(0, '0, 1, 0, 0);
    step(0, '0, 0, 0, 0);

    // 16-block measured run with a free-running consumer
    step(0, '0, 1, 1, 16);
    for (int i = 0; i < 16; i++) step(1, rnd128(), 1, 0, 0);
    step(0, '0, 1, 0, 0);
    step(0, '0, 1, 0, 0);

    // overflow: 17 pushes with no consumer, then push+pop at full, then drain
    for (int i = 0; i < 17; i++) step(1, rnd128(), 0, 0, 0);
    check("ovf_after_17", overflow, 1'b1);
    step(1, rnd128(), 1, 1, 3);
    for (int i = 0; i < 18; i++) step(0, '0, 1, 0, 0);

    // zero-length run and start coinciding with a push
    step(0, '0, 0, 1, 0);
    step(0, '0, 0, 0, 0);
    step(0, '0, 0, 0, 0);
    step(1, rnd128(), 0, 1, 5);
    for (int i = 0; i < 4; i++) step(1, rnd128(), 0, 0, 0);
    rst_n = 0;
    step(0, '0, 0, 0, 0);
    check("rst_mid_m_data", m_data, 128'h0);
    rst_n = 1;

    // randomized traffic with occasional starts and resets
    for (int i = 0; i < 600; i++) begin
      logic st;
      st = ($urandom_range(0, 39) == 0);
      rst_n = ($urandom_range(0, 199) != 0);
      step($urandom_range(0, 99) < 60, rnd128(), $urandom_range(0, 99) < 45,
           st, 16'($urandom_range(0, 20)));
    end
    rst_n = 1;
    for (int i = 0; i < 20; i++) step(0, '0, 1, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/aes_output_collector.md
# aes_output_collector

Receive-side companion to `aes_pipelined`: accepts the core's unthrottled `valid_out`/`data_out` result stream, buffers it in a FIFO, and presents it to a downstream consumer over a valid/ready handshake. It also counts received blocks and measures run length in cycles, so hardware throughput figures match the bench methodology. Instantiated directly at the core's output, same clock domain.

## Interface
- `DEPTH`, 16, FIFO entries; power of two, ≥2
- `DATA_W`, 128, block width
- `CNT_W`, 16, width of block counters
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  reset, synchronous and active-low; one clock, this block uses only `clk`
- `in_valid`  in  1  result strobe from core `valid_out`; no backpressure available
- `in_data`  in  DATA_W  result from core `data_out`
- `m_valid`  out  1  FIFO head valid
- `m_ready`  in  1  consumer accepts head
- `m_data`  out  DATA_W  FIFO head data
- `level`  out  $clog2(DEPTH)+1  current occupancy
- `overflow`  out  1  sticky: a block was dropped
- `start`  in  1  one-cycle pulse: begin measured run
- `expected_blocks`  in  CNT_W  run length, sampled on `start`
- `blk_count`  out  CNT_W  blocks accepted in current run
- `done`  out  1  run complete
- `elapsed_cycles`  out  32  run duration in cycles

## Operation
- Push = `in_valid && (!full || pop)`. Pop = `m_valid && m_ready`. The block writes and pops simultaneously when full.
- When `in_valid` is asserted while full and there is no pop, the block drops the input and sets `overflow`. `overflow` clears only on `rst_n` or `start`.
- The FIFO is first-word-fall-through from registered storage. `m_data` holds the head whenever `m_valid` is high and is stable while `m_ready` is low.
- Pointers wrap modulo DEPTH. `level` updates as +1 on push, −1 on pop, and is unchanged when both occur.
- FSM states:
  - IDLE: entered on reset. Goes to RUN on `start`.
  - RUN: on each cycle with an accepted push, `blk_count`+1. When the accepted push makes `blk_count == expected_blocks`, go to DONE.
  - DONE: `done`=1. Goes to RUN on `start`.
- `start` in any state:
  - Clears `blk_count`, `elapsed_cycles`, `done`, and `overflow`.
  - Latches `expected_blocks`.
  - Does not flush the FIFO.
- If a push coincides with `start`, it is counted as block 1 of the new run.
- `expected_blocks` = 0 at `start`: DONE on the next edge, `elapsed_cycles` = 0.
- In IDLE/DONE, pushes still enter the FIFO but are not counted.
- Dropped blocks are never counted.
- `blk_count` and `elapsed_cycles` saturate at all-ones.

## Timing
- Reset values: `m_valid`=0, `m_data`=0, `level`=0, `overflow`=0, `blk_count`=0, `done`=0, `elapsed_cycles`=0, FSM in IDLE, pointers 0.
- `rst_n` low mid-run: all of the above apply on that edge, and FIFO contents are discarded.
- Push on edge N into an empty FIFO: `m_valid`=1 after edge N, so latency is 1 cycle. There is no combinational bypass from `in_data` to `m_data`.
- A pop on edge N presents the next entry after edge N.
- `elapsed_cycles`:
  - Set to 0 on the `start` edge.
  - +1 on each subsequent edge in RUN, including the edge that accepts the final block.
  - Frozen in DONE.
  - Example: 16 back-to-back pushes beginning the edge after `start` → 16.
- `done` rises on the edge that accepts the final block.

## Configuration
- `AES_COLLECT_PERF_EN` defined: the `elapsed_cycles` counter is compiled in as described.
- `AES_COLLECT_PERF_EN` undefined: no cycle counter exists, and `elapsed_cycles` is tied to 0. FIFO, `blk_count`, `done`, and `overflow` behave identically in both builds.

## Test plan
- Reset, then a single push of 69c4e0d86a7b0430d8cdb78070b4c55a with `m_ready`=0 → `m_valid`=1 one cycle later with that data, `level`=1. Raise `m_ready` for one cycle → `m_valid`=0, `level`=0.
- `start` with `expected_blocks`=16, then 16 back-to-back pushes with `m_ready`=1 → all 16 blocks out in order, `blk_count`=16, `done`=1, `elapsed_cycles`=16, `overflow`=0.
- `m_ready`=0 and 17 pushes with DEPTH=16 → `level`=16, `overflow`=1, and the 17th block is absent. Drain → blocks 1–16 in order.
- Full FIFO with a push and pop on the same edge → accepted, `level` stays 16, `overflow`=0.
- `start` with `expected_blocks`=0 → `done`=1 next cycle, `elapsed_cycles`=0. `start` coincident with a push → `blk_count`=1.
- `rst_n` low mid-run with 5 entries buffered → next cycle all outputs are at their reset values and `m_valid`=0. Rerun without `AES_COLLECT_PERF_EN` → `elapsed_cycles` stays 0.
